ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
- PS/2 device-to-host receiver and scan-code decoder. Produces the held-key byte that the pixel/paddle generator consumes as its keyboard input.
- Samples the keyboard's open-collector clock and data lines and deframes 11-bit frames.
- Tracks make, break (F0) and extended (E0) prefixes.
- Presents a level-valued "currently held key" code, plus a per-byte strobe for debug.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized ps2_clk samples required before the filtered clock changes state.
- TIMEOUT_CYCLES, 100000: clk cycles without a filtered falling edge mid-frame before the frame is aborted (2 ms at 50 MHz).
- TO_W, 17: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk, input, 1: system clock (50 MHz).
- reset, input, 1: synchronous, active-high reset.
- ps2_clk, input, 1: raw PS/2 clock from the keyboard; asynchronous.
- ps2_data, input, 1: raw PS/2 data from the keyboard; asynchronous.
- key_code, output, 8: make code of the currently held key; 8'h00 when no key is held.
- key_ext, output, 1: set when key_code came from an E0-prefixed make code.
- rx_byte, output, 8: last correctly received raw byte.
- rx_valid, output, 1: one-cycle strobe; rx_byte was updated this cycle.
- frame_err, output, 1: one-cycle strobe on a bad start bit, parity error, stop-bit error, or timeout.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: key_code=00, key_ext=0, rx_byte=00, rx_valid=0, frame_err=0. Deframer returns to IDLE, E0/F0 flags clear, filtered clock =1, timeout counter =0. Reset asserted mid-frame discards the partial frame; no strobe is produced.
- Input conditioning:
  - 2-FF synchronizer on each of ps2_clk and ps2_data.
  - Filter: a counter tracks how long the synchronized clock has differed from the filtered clock. The filtered clock flips only after FILTER_LEN consecutive differing samples. Glitches shorter than FILTER_LEN are ignored.
  - fall = filtered clock 1 in the previous cycle and 0 in this cycle. Data is sampled (synchronized value) in the fall cycle.
- Deframer FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on fall, if data=0 go to DATA with bit count 0. If data=1, pulse frame_err and stay in IDLE.
  - DATA: on fall, shift data into bit[count], LSB first. After the 8th bit go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, require stop=1 and odd parity (XOR of the 8 data bits and the parity bit = 1).
    - Pass: rx_byte <= data and rx_valid=1 in the next cycle.
    - Fail: frame_err=1 in the next cycle, rx_byte unchanged.
    - Either way return to IDLE.
  - Timeout: the timeout counter resets on every fall and counts in every non-IDLE state. When it reaches TIMEOUT_CYCLES-1: frame_err pulse, go to IDLE, and clear the E0/F0 flags.
- Decoder, acting in the cycle after rx_valid, so key_code latency is 1 cycle after rx_valid:
  - Byte E0: set ext flag.
  - Byte F0: set brk flag.
  - Byte AA (self-test pass): ignored.
  - Any other byte b with brk=1: if b==key_code and ext==key_ext, then key_code=00 and key_ext=0; otherwise no change. Clear both flags.
  - Any other byte b with brk=0: key_code=b, key_ext=ext. Clear both flags. A new make overrides the previous key; typematic repeats rewrite the same value.
  - frame_err clears both flags; key_code is unchanged.
- Strobes are never asserted simultaneously. rx_valid and frame_err are each high for exactly one cycle.

Test Plan:
- Send frame for 1D (data bits 1,0,1,1,1,0,0,0; parity 1; stop 1) at 12.5 kHz -> rx_valid one cycle with rx_byte=1D; next cycle key_code=1D, key_ext=0.
- Send 1D, then F0, then 1D -> key_code=1D after the first byte, unchanged after F0, 00 after the final 1D. Three rx_valid pulses total.
- Send E0, 75, then E0, F0, 75 -> key_code=75 with key_ext=1; then key_code=00 with key_ext=0.
- Send 76 with parity bit inverted -> frame_err pulse, no rx_valid, key_code stays at its previous value.
- Send start plus 4 data bits, then hold ps2_clk high for 110000 cycles -> exactly one frame_err. A following valid 23 frame decodes as key_code=23.
- Inject 3-cycle low glitches on ps2_clk while idle and mid-frame (FILTER_LEN=8) -> no extra bits, no strobes. Assert reset mid-frame -> all outputs 0, and the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: input conditioning, 11-bit frame deframer and
// scan-code decoder that tracks the currently held key.
//
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-high reset
//   ps2_clk   - raw PS/2 clock (asynchronous)
//   ps2_data  - raw PS/2 data (asynchronous)
//   key_code  - make code of held key, 8'h00 when none
//   key_ext   - held key came from an E0-prefixed make code
//   rx_byte   - last correctly received raw byte
//   rx_valid  - one-cycle strobe, rx_byte updated
//   frame_err - one-cycle strobe on start/parity/stop error or timeout

module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // synchronizers
  logic r_clk_s1;
  logic r_clk_s2;
  logic r_dat_s1;
  logic r_dat_s2;

  // clock filter
  logic          r_filt;
  logic          r_filt_d;
  logic [FW-1:0] r_fcnt;

  // deframer
  state_t        r_state;
  state_t        w_state_nx;
  logic [7:0]    r_shift;
  logic [2:0]    r_cnt;
  logic          r_par;
  logic [TO_W-1:0] r_to;

  // strobes and outputs
  logic       r_rx_valid;
  logic       r_frame_err;
  logic [7:0] r_rx_byte;
  logic [7:0] r_key;
  logic       r_key_ext;
  logic       r_ext;
  logic       r_brk;

  // combinational controls
  logic w_fall;
  logic w_dat;
  logic w_tmo;
  logic w_clr;
  logic w_shift;
  logic w_cap_par;
  logic w_ok;
  logic w_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered clock only follows the synchronized clock once it has
  // disagreed for FILTER_LEN samples in a row; any agreeing sample
  // restarts the count, so short glitches never reach the deframer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s2 != r_filt) begin
        if (r_fcnt == FW'(FILTER_LEN - 1)) begin
          r_filt <= r_clk_s2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  assign w_fall = r_filt_d & ~r_filt;
  assign w_dat  = r_dat_s2;

  // A fall in the same cycle restarts the count, so it wins over timeout.
  assign w_tmo = (r_state != IDLE) && !w_fall &&
                 (r_to == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_clr      = 1'b0;
    w_shift    = 1'b0;
    w_cap_par  = 1'b0;
    w_ok       = 1'b0;
    w_err      = 1'b0;
    if (w_tmo) begin
      w_state_nx = IDLE;
      w_err      = 1'b1;
    end else if (w_fall) begin
      unique case (r_state)
        IDLE: begin
          if (!w_dat) begin
            w_state_nx = DATA;
            w_clr      = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        DATA: begin
          w_shift = 1'b1;
          if (r_cnt == 3'd7) begin
            w_state_nx = PARITY;
          end
        end
        PARITY: begin
          w_cap_par  = 1'b1;
          w_state_nx = STOP;
        end
        STOP: begin
          w_state_nx = IDLE;
          // odd parity over data plus parity bit, and stop must be 1
          if (w_dat && ((^r_shift) ^ r_par)) begin
            w_ok = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: begin
          w_state_nx = IDLE;
        end
      endcase
    end
  end

  // Data path of the deframer. LSB arrives first, so shifting right
  // leaves bit 0 in r_shift[0] after eight shifts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
    end else begin
      if (w_clr) begin
        r_cnt <= '0;
      end
      if (w_shift) begin
        r_shift <= {w_dat, r_shift[7:1]};
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_cap_par) begin
        r_par <= w_dat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to <= '0;
    end else if (r_state == IDLE || w_fall) begin
      r_to <= '0;
    end else begin
      r_to <= r_to + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_byte   <= '0;
    end else begin
      r_rx_valid  <= w_ok;
      r_frame_err <= w_err;
      if (w_ok) begin
        r_rx_byte <= r_shift;
      end
    end
  end

  // Scan-code decoder, one cycle behind the byte strobe. A break only
  // releases the key if it names exactly the held key, including E0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key     <= '0;
      r_key_ext <= 1'b0;
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
    end else if (r_frame_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_rx_valid) begin
      unique case (1'b1)
        (r_rx_byte == 8'hE0): begin
          r_ext <= 1'b1;
        end
        (r_rx_byte == 8'hF0): begin
          r_brk <= 1'b1;
        end
        (r_rx_byte == 8'hAA): begin
          r_ext <= r_ext;
        end
        default: begin
          if (r_brk) begin
            if (r_rx_byte == r_key && r_ext == r_key_ext) begin
              r_key     <= '0;
              r_key_ext <= 1'b0;
            end
          end else begin
            r_key     <= r_rx_byte;
            r_key_ext <= r_ext;
          end
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      endcase
    end
  end

  assign key_code  = r_key;
  assign key_ext   = r_key_ext;
  assign rx_byte   = r_rx_byte;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Testbench for ps2_keyboard_rx: randomized PS/2 frames checked by a
// scoreboard fed from a scan-code reference model.

module tb_ps2_keyboard_rx;

  localparam int HALF = 40;
  localparam int TMO  = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  ps2_keyboard_rx #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TMO),
    .TO_W          (11)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_code (key_code),
    .key_ext  (key_ext),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] b;
    logic [7:0] key;
    bit         ext;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  // reference model: held key plus pending prefixes
  logic [7:0] m_key = 8'h00;
  bit         m_ext = 1'b0;
  bit         m_e0 = 1'b0;
  bit         m_brk = 1'b0;

  logic [7:0] pool [8] = '{8'h1D, 8'h23, 8'h75, 8'h1C,
                           8'hAA, 8'hE0, 8'hF0, 8'h2B};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_byte(logic [7:0] b);
    if (b == 8'hE0) m_e0 = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hAA) m_e0 = m_e0;
    else begin
      if (m_brk) begin
        if (b == m_key && m_e0 == m_ext) begin
          m_key = 8'h00;
          m_ext = 1'b0;
        end
      end else begin
        m_key = b;
        m_ext = m_e0;
      end
      m_e0 = 1'b0;
      m_brk = 1'b0;
    end
    sbq.push_back('{err: 1'b0, b: b, key: m_key, ext: m_ext});
  endtask

  task automatic model_err();
    m_e0 = 1'b0;
    m_brk = 1'b0;
    sbq.push_back('{err: 1'b1, b: 8'h00, key: m_key, ext: m_ext});
  endtask

  task automatic send_bits(logic [10:0] f, int n, bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      if (glitch) begin
        cyc(15);
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(HALF - 18);
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(logic [7:0] b, bit fpar, bit bstop, bit gl);
    logic [10:0] f;
    f = {~bstop, (~^b) ^ fpar, b, 1'b0};
    if (fpar || bstop) model_err();
    else model_byte(b);
    send_bits(f, 11, gl);
    cyc(60);
  endtask

  task automatic send_bad_start();
    model_err();
    send_bits(11'h001, 1, 1'b0);
    cyc(60);
  endtask

  // monitor: pop on every strobe, check key one cycle later
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (rx_valid || frame_err)) begin
        chk("strobe_excl", 32'(rx_valid & frame_err), 0);
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe act=v%0b/e%0b exp=none",
                   rx_valid, frame_err);
        end else begin
          e = sbq.pop_front();
          chk("kind_err", 32'(frame_err), 32'(e.err));
          if (!e.err) chk("rx_byte", 32'(rx_byte), 32'(e.b));
          @(negedge clk);
          chk("key_code", 32'(key_code), 32'(e.key));
          chk("key_ext", 32'(key_ext), 32'(e.ext));
          chk("strobe_1cyc", 32'(rx_valid | frame_err), 0);
        end
      end
    end
  end

  initial begin
    logic [7:0]  b;
    logic [10:0] pf;
    int          r;
    int          w;
    cyc(4);
    chk("rst_key", 32'(key_code), 0);
    chk("rst_ext", 32'(key_ext), 0);
    chk("rst_byte", 32'(rx_byte), 0);
    chk("rst_strb", 32'(rx_valid | frame_err), 0);
    reset = 1'b0;
    cyc(20);

    // make / break
    send_byte(8'h1D, 0, 0, 0);
    send_byte(8'hF0, 0, 0, 0);
    send_byte(8'h1D, 0, 0, 0);
    // extended make / break
    send_byte(8'hE0, 0, 0, 0);
    send_byte(8'h75, 0, 0, 0);
    send_byte(8'hE0, 0, 0, 0);
    send_byte(8'hF0, 0, 0, 0);
    send_byte(8'h75, 0, 0, 0);
    // parity error leaves key
    send_byte(8'h1C, 0, 0, 0);
    send_byte(8'h76, 1, 0, 0);
    send_byte(8'h76, 0, 1, 0);
    send_bad_start();
    // timeout mid-frame, then recovery
    model_err();
    pf = {2'b11, 8'h23, 1'b0};
    send_bits(pf, 5, 1'b0);
    cyc(TMO + 200);
    send_byte(8'h23, 0, 0, 0);
    // glitches while idle and inside a frame
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0;
      cyc(3);
      ps2_clk = 1'b1;
      cyc(50);
    end
    send_byte(8'h1C, 0, 0, 1);
    // reset mid-frame
    pf = {2'b10, 8'h2B, 1'b0};
    send_bits(pf, 6, 1'b0);
    reset = 1'b1;
    cyc(3);
    chk("mrst_key", 32'(key_code), 0);
    chk("mrst_ext", 32'(key_ext), 0);
    chk("mrst_byte", 32'(rx_byte), 0);
    chk("mrst_strb", 32'(rx_valid | frame_err), 0);
    m_key = 8'h00;
    m_ext = 1'b0;
    m_e0 = 1'b0;
    m_brk = 1'b0;
    reset = 1'b0;
    cyc(20);
    send_byte(8'h2B, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) b = pool[$urandom_range(0, 7)];
      else b = 8'($urandom);
      if (r <= 6) send_byte(b, 0, 0, $urandom_range(0, 3) == 0);
      else if (r == 7) send_byte(b, 1, 0, 0);
      else if (r == 8) send_byte(b, 0, 1, 0);
      else send_bad_start();
    end

    w = 0;
    while (sbq.size() != 0 && w < 500) begin
      cyc(1);
      w++;
    end
    cyc(5);
    chk("drain", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
